// File: rtl/bsg_scheduler_resource_age_pkg.sv
// Shared types and constants for the age-ordered resource scheduler.
// Optional wait counters: BSG_SCHEDULER_RESOURCE_AGE_WAIT_CNT_EN.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package bsg_scheduler_resource_age_pkg;

  localparam int wait_cnt_width_gp = 8;
  localparam int max_id_width_gp  = 8;
  localparam int max_res_width_gp = 32;

  typedef struct packed {
    logic [max_id_width_gp-1:0]  id;
    logic [max_res_width_gp-1:0] res;
  } deq_port_s;

endpackage

// File: rtl/bsg_age_matrix_select.sv
// Age matrix storage plus iterative oldest-first grant selection.
// Row i bit j set means entry i is older than entry j.
module bsg_age_matrix_select
  import bsg_scheduler_resource_age_pkg::*;
#(
  parameter int els_p       = 8,
  parameter int deq_ports_p = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               flush_i,
  input  logic                               alloc_i,
  input  logic [els_p-1:0]                   alloc_oh_i,
  input  logic [els_p-1:0]                   active_i,
  input  logic [els_p-1:0]                   ready_i,
  output logic [deq_ports_p-1:0][els_p-1:0]  grant_o
);

  logic [els_p-1:0][els_p-1:0] age_q, age_d;
  logic [els_p-1:0]            rem;
  logic [deq_ports_p-1:0][els_p-1:0] g;
  logic                        older;

  // New entry is younger than every active entry; flush clears all.
  always_comb begin
    age_d = age_q;
    if (flush_i) begin
      age_d = '0;
    end else if (alloc_i) begin
      for (int n = 0; n < els_p; n++) begin
        if (alloc_oh_i[n]) begin
          for (int j = 0; j < els_p; j++) begin
            age_d[j][n] = active_i[j];
            age_d[n][j] = 1'b0;
          end
        end
      end
    end
  end

  // Age matrix register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) age_q <= '0;
    else            age_q <= age_d;
  end

  // Each port takes the oldest ready entry left by earlier ports.
  always_comb begin
    rem   = ready_i;
    g     = '0;
    older = 1'b0;
    for (int k = 0; k < deq_ports_p; k++) begin
      for (int i = 0; i < els_p; i++) begin
        older = 1'b0;
        for (int j = 0; j < els_p; j++) begin
          older = older | (rem[j] & age_q[j][i]);
        end
        g[k][i] = rem[i] & ~older;
      end
      rem = rem & ~g[k];
    end
  end

  assign grant_o = g;

endmodule

// File: rtl/bsg_scheduler_resource_age.sv
// Multi-resource scheduler issuing ready entries oldest first.
// Optional per-entry wait counters: BSG_SCHEDULER_RESOURCE_AGE_WAIT_CNT_EN.
module bsg_scheduler_resource_age
  import bsg_scheduler_resource_age_pkg::*;
#(
  parameter int resources_p    = 2,
  parameter int els_p          = 8,
  parameter int max_dep_bits_p = 4,
  parameter int deq_ports_p    = 2,
  localparam int dep_width_lp  = `BSG_SAFE_CLOG2(max_dep_bits_p),
  localparam int id_width_lp   = `BSG_SAFE_CLOG2(els_p)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic flush_i,
  input  logic [resources_p-1:0][max_dep_bits_p-1:0] res_avail_i,
  input  logic alloc_v_i,
  input  logic [resources_p-1:0][dep_width_lp-1:0] alloc_sel_i,
  output logic alloc_yumi_o,
  output logic [id_width_lp-1:0] alloc_id_o,
  output logic [deq_ports_p-1:0] deq_v_o,
  output logic [deq_ports_p-1:0][id_width_lp-1:0] deq_id_o,
  output logic [deq_ports_p-1:0][resources_p-1:0][dep_width_lp-1:0]
    deq_res_o,
`ifdef BSG_SCHEDULER_RESOURCE_AGE_WAIT_CNT_EN
  output logic [deq_ports_p-1:0][wait_cnt_width_gp-1:0] deq_wait_o,
`endif
  input  logic [deq_ports_p-1:0] deq_yumi_i,
  output logic empty_o,
  output logic full_o
);

  logic [els_p-1:0] active_q, active_d;
  logic [els_p-1:0][resources_p-1:0][dep_width_lp-1:0] sel_q;
  logic [els_p-1:0] ready;
  logic [els_p-1:0] alloc_oh;
  logic [els_p-1:0] deq_clr;
  logic [deq_ports_p-1:0][els_p-1:0] grant;
  logic alloc_take;

  assign full_o       = &active_q;
  assign empty_o      = ~|active_q;
  assign alloc_yumi_o = alloc_v_i & ~full_o & ~flush_i & reset_n_i;
  assign alloc_take   = alloc_yumi_o;

  // Lowest free slot from registered state.
  always_comb begin
    alloc_oh   = '0;
    alloc_id_o = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
        alloc_id_o  = id_width_lp'(i);
      end
    end
  end

  // Entry is ready when active and every selected bit is set.
  always_comb begin
    ready = '0;
    for (int i = 0; i < els_p; i++) begin
      ready[i] = active_q[i];
      for (int r = 0; r < resources_p; r++) begin
        ready[i] = ready[i] & res_avail_i[r][sel_q[i][r]];
      end
    end
  end

  bsg_age_matrix_select #(
    .els_p       (els_p),
    .deq_ports_p (deq_ports_p)
  ) age_sel (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .flush_i    (flush_i),
    .alloc_i    (alloc_take),
    .alloc_oh_i (alloc_oh),
    .active_i   (active_q),
    .ready_i    (ready),
    .grant_o    (grant)
  );

`ifdef BSG_SCHEDULER_RESOURCE_AGE_WAIT_CNT_EN
  logic [els_p-1:0][wait_cnt_width_gp-1:0] wait_q;
`endif

  // Encode grants into issue ports and collect accepted entries.
  always_comb begin
    deq_v_o   = '0;
    deq_id_o  = '0;
    deq_res_o = '0;
    deq_clr   = '0;
`ifdef BSG_SCHEDULER_RESOURCE_AGE_WAIT_CNT_EN
    deq_wait_o = '0;
`endif
    for (int k = 0; k < deq_ports_p; k++) begin
      deq_v_o[k] = |grant[k];
      for (int i = 0; i < els_p; i++) begin
        if (grant[k][i]) begin
          deq_id_o[k]  = id_width_lp'(i);
          deq_res_o[k] = sel_q[i];
`ifdef BSG_SCHEDULER_RESOURCE_AGE_WAIT_CNT_EN
          deq_wait_o[k] = wait_q[i];
`endif
        end
      end
      if (deq_yumi_i[k]) deq_clr = deq_clr | grant[k];
    end
  end

  // Accepted entries retire, new entry joins, flush wins.
  always_comb begin
    active_d = active_q & ~deq_clr;
    if (alloc_take) active_d = active_d | alloc_oh;
    if (flush_i)    active_d = '0;
  end

  // Active bit register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) active_q <= '0;
    else            active_q <= active_d;
  end

  // Resource indices; only observed through active-gated paths.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if (alloc_take && alloc_oh[i]) sel_q[i] <= alloc_sel_i;
    end
  end

`ifdef BSG_SCHEDULER_RESOURCE_AGE_WAIT_CNT_EN
  // Saturating count of cycles spent ready but not issued.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wait_q <= '0;
    end else begin
      for (int i = 0; i < els_p; i++) begin
        if (alloc_take && alloc_oh[i]) begin
          wait_q[i] <= '0;
        end else if (ready[i] && !deq_clr[i] && !(&wait_q[i])) begin
          wait_q[i] <= wait_q[i] + 1'b1;
        end
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Handshake and grant uniqueness checks.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      for (int k = 0; k < deq_ports_p; k++) begin
        assert (!deq_yumi_i[k] || deq_v_o[k])
          else $error("deq_yumi_i without deq_v_o on port %0d", k);
        for (int m = k + 1; m < deq_ports_p; m++) begin
          assert (!(deq_v_o[k] && deq_v_o[m] && deq_id_o[k] == deq_id_o[m]))
            else $error("ports %0d and %0d grant the same id", k, m);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_scheduler_resource_age.sv
// Directed bench with a timestamp-ordered reference model.
// Default build (wait counters off) with 2 resources, 8 entries, 2 ports.
`timescale 1ns/1ps
module tb_bsg_scheduler_resource_age;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [1:0][3:0] avail = 8'hFF;
  logic alloc_v = 1'b0;
  logic [1:0][1:0] asel = '0;
  logic ayumi;
  logic [2:0] aid;
  logic [1:0] dv;
  logic [1:0][2:0] did;
  logic [1:0][1:0][1:0] dres;
  logic [1:0] yumi = '0;
  logic empty, full;
`ifdef BSG_SCHEDULER_RESOURCE_AGE_WAIT_CNT_EN
  logic [1:0][7:0] dwait;
`endif

  int nvec = 0;
  int nerr = 0;

  bit       m_act [8];
  int       m_ts  [8];
  bit [3:0] m_sel [8];
  int       seq = 0;

  always #5 clk = ~clk;

  bsg_scheduler_resource_age #(
    .resources_p    (2),
    .els_p          (8),
    .max_dep_bits_p (4),
    .deq_ports_p    (2)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .flush_i      (flush),
    .res_avail_i  (avail),
    .alloc_v_i    (alloc_v),
    .alloc_sel_i  (asel),
    .alloc_yumi_o (ayumi),
    .alloc_id_o   (aid),
    .deq_v_o      (dv),
    .deq_id_o     (did),
    .deq_res_o    (dres),
`ifdef BSG_SCHEDULER_RESOURCE_AGE_WAIT_CNT_EN
    .deq_wait_o   (dwait),
`endif
    .deq_yumi_i   (yumi),
    .empty_o      (empty),
    .full_o       (full)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int i);
    logic [7:0] av;
    bit [3:0] s;
    av = avail;
    s  = m_sel[i];
    return m_act[i] && av[int'(s[1:0])] && av[4 + int'(s[3:2])];
  endfunction

  task automatic m_pick(output int p0, output int p1);
    p0 = -1;
    p1 = -1;
    for (int i = 0; i < 8; i++)
      if (m_ready(i) && (p0 < 0 || m_ts[i] < m_ts[p0])) p0 = i;
    for (int i = 0; i < 8; i++)
      if (i != p0 && m_ready(i) && (p1 < 0 || m_ts[i] < m_ts[p1])) p1 = i;
  endtask

  function automatic int m_free();
    for (int i = 0; i < 8; i++) if (!m_act[i]) return i;
    return -1;
  endfunction

  // Per-cycle compare against the model, then advance the model.
  initial begin
    int p0, p1, fr;
    bit mf, me;
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        m_pick(p0, p1);
        fr = m_free();
        mf = (fr < 0);
        me = 1'b1;
        for (int i = 0; i < 8; i++) if (m_act[i]) me = 1'b0;
        chk("m_full", 32'(full), 32'(mf));
        chk("m_empty", 32'(empty), 32'(me));
        chk("m_alloc_yumi", 32'(ayumi), 32'(alloc_v && !mf && !flush));
        if (!mf) chk("m_alloc_id", 32'(aid), 32'(fr));
        chk("m_deq_v", 32'(dv), 32'({p1 >= 0, p0 >= 0}));
        chk("m_deq_id0", 32'(did[0]), (p0 >= 0) ? 32'(p0) : 32'd0);
        chk("m_deq_id1", 32'(did[1]), (p1 >= 0) ? 32'(p1) : 32'd0);
        chk("m_deq_res0", 32'(dres[0]), (p0 >= 0) ? 32'(m_sel[p0]) : 32'd0);
        chk("m_deq_res1", 32'(dres[1]), (p1 >= 0) ? 32'(m_sel[p1]) : 32'd0);
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) m_act[i] = 1'b0;
      end else begin
        // Inputs are unchanged since the edge just taken.
        fr = m_free();
        if (flush) begin
          for (int i = 0; i < 8; i++) m_act[i] = 1'b0;
        end else begin
          if (yumi[0] && p0 >= 0) m_act[p0] = 1'b0;
          if (yumi[1] && p1 >= 0) m_act[p1] = 1'b0;
          if (alloc_v && fr >= 0) begin
            m_act[fr] = 1'b1;
            m_sel[fr] = asel;
            m_ts[fr]  = seq;
            seq++;
          end
        end
      end
    end
  end

  task automatic cyc(input logic av_in, input logic [3:0] s,
                     input logic [1:0] y, input logic fl,
                     input logic [7:0] rv);
    @(negedge clk); #1;
    alloc_v = av_in;
    asel    = s;
    yumi    = y;
    flush   = fl;
    avail   = rv;
    #2;
  endtask

  initial begin
    alloc_v = 1'b1;
    #3;
    chk("rst_alloc_yumi", 32'(ayumi), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_deq_v", 32'(dv), 32'd0);
    chk("rst_deq_id", 32'(did), 32'd0);
    chk("rst_deq_res", 32'(dres), 32'd0);
    alloc_v = 1'b0;
    #21 rst_n = 1'b1;

    cyc(1, 4'b1001, 2'b00, 0, 8'hFF);
    chk("a0_yumi", 32'(ayumi), 32'd1);
    chk("a0_id", 32'(aid), 32'd0);
    cyc(1, 4'b1100, 2'b00, 0, 8'hFF);
    chk("a1_id", 32'(aid), 32'd1);
    chk("a1_deq_v", 32'(dv), 32'b01);
    cyc(1, 4'b0011, 2'b00, 0, 8'hFF);
    chk("a2_id", 32'(aid), 32'd2);
    chk("a2_deq_v", 32'(dv), 32'b11);
    chk("a2_deq_id", 32'(did), 32'b001_000);
    cyc(0, 4'b0000, 2'b00, 0, 8'hFF);
    chk("res0", 32'(dres[0]), 32'b1001);
    chk("res1", 32'(dres[1]), 32'b1100);
    cyc(0, 4'b0000, 2'b00, 0, 8'hFD);
    chk("blk_id", 32'(did), 32'b010_001);
    cyc(0, 4'b0000, 2'b00, 0, 8'hFF);
    chk("unblk_id", 32'(did), 32'b001_000);

    for (int n = 3; n < 8; n++) cyc(1, 4'b0010, 2'b00, 0, 8'hFF);
    cyc(1, 4'b0010, 2'b01, 0, 8'hF4);
    chk("full", 32'(full), 32'd1);
    chk("full_yumi", 32'(ayumi), 32'd0);
    chk("full_deq0", 32'(did[0]), 32'd3);
    cyc(1, 4'b0010, 2'b00, 0, 8'hF4);
    chk("realloc_full", 32'(full), 32'd0);
    chk("realloc_id", 32'(aid), 32'd3);
    chk("realloc_yumi", 32'(ayumi), 32'd1);
    chk("realloc_deq0", 32'(did[0]), 32'd4);
    cyc(0, 4'b0000, 2'b00, 0, 8'hFF);
    chk("order_a", 32'(did), 32'b001_000);

    cyc(0, 4'b0000, 2'b01, 0, 8'hFF);
    cyc(1, 4'b0000, 2'b00, 0, 8'hFF);
    chk("id0_again", 32'(aid), 32'd0);
    cyc(0, 4'b0000, 2'b11, 0, 8'hFF);
    chk("drain1", 32'(did), 32'b010_001);
    cyc(0, 4'b0000, 2'b11, 0, 8'hFF);
    chk("drain2", 32'(did), 32'b101_100);
    cyc(0, 4'b0000, 2'b11, 0, 8'hFF);
    chk("drain3", 32'(did), 32'b111_110);
    cyc(0, 4'b0000, 2'b11, 0, 8'hFF);
    chk("youngest_last", 32'(did), 32'b000_011);
    cyc(0, 4'b0000, 2'b00, 0, 8'hFF);
    chk("drained_empty", 32'(empty), 32'd1);

    for (int n = 0; n < 5; n++) cyc(1, 4'b0000, 2'b00, 0, 8'hFF);
    cyc(1, 4'b0000, 2'b11, 1, 8'hFF);
    chk("flush_yumi", 32'(ayumi), 32'd0);
    chk("flush_deq_v", 32'(dv), 32'b11);
    cyc(0, 4'b0000, 2'b00, 0, 8'hFF);
    chk("post_flush_empty", 32'(empty), 32'd1);
    chk("post_flush_v", 32'(dv), 32'd0);

    for (int n = 0; n < 3; n++) cyc(1, 4'b0110, 2'b00, 0, 8'hFF);
    cyc(1, 4'b0000, 2'b00, 0, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_deq_v", 32'(dv), 32'd0);
    chk("arst_deq_id", 32'(did), 32'd0);
    chk("arst_deq_res", 32'(dres), 32'd0);
    chk("arst_yumi", 32'(ayumi), 32'd0);
    alloc_v = 1'b0;
    @(negedge clk); #4 rst_n = 1'b1;
    cyc(1, 4'b0000, 2'b00, 0, 8'hFF);
    chk("post_rst_id", 32'(aid), 32'd0);
    chk("post_rst_yumi", 32'(ayumi), 32'd1);
    cyc(0, 4'b0000, 2'b00, 0, 8'hFF);
    @(negedge clk); #4;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
